// File: rtl/brick_field.sv
// Destructible brick map: loads the level one row per frame, then clears cells struck by the player bullet.
// Latency: load completes 30 edges after reset release; a hit is visible one edge after the inputs are sampled.
// Backpressure: none; after a hit the bullet must drop bullet_active for one cycle before it can hit again.
module brick_field #(
    parameter int ROWS      = 30,
    parameter int COLS      = 40,
    parameter int BULLET_SZ = 8
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             bullet_active,
    input  logic [9:0]       bullet_x,
    input  logic [9:0]       bullet_y,
    input  logic [3:0]       bullet_dir,
    output logic [COLS-1:0]  brick_map [0:ROWS-1],
    output logic             bullet_hit,
    output logic             ready,
    output logic [10:0]      bricks_left,
    output logic             all_clear
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [10:0] S     = 11'(BULLET_SZ - 1);
    localparam logic [10:0] X_MAX = 11'(COLS * 16 - 1);
    localparam logic [10:0] Y_MAX = 11'(ROWS * 16 - 1);

    typedef enum logic [1:0] {LOAD, ARMED, SPENT} state_t;

    state_t          state;
    logic [RW-1:0]   rc;

    function automatic logic [COLS-1:0] level_row(input logic [RW-1:0] r);
        logic [COLS-1:0] row;
        int ri;
        row = '0;
        ri  = int'(r);
        for (int c = 0; c < COLS; c++) begin
            row[COLS-1-c] = (ri >= 4) && (ri <= 25) && (c >= 6) && (c <= 33) &&
                            ((ri % 4) < 2) && ((c % 4) < 2) &&
                            !((ri >= 12) && (ri <= 17) && (c >= 18) && (c <= 23));
        end
        return row;
    endfunction

    function automatic logic [10:0] popcount(input logic [COLS-1:0] v);
        logic [10:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) n = n + 11'(v[i]);
        return n;
    endfunction

    logic [COLS-1:0] load_row;
    logic [10:0]     load_cnt;

    assign load_row = level_row(rc);
    assign load_cnt = popcount(load_row);

    // Two leading-edge probe points, selected by travel direction.
    logic [10:0] xl, xr, yt, yb;
    logic [10:0] x0, y0, x1, y1;
    logic        dir_ok;

    assign xl = {1'b0, bullet_x};
    assign xr = xl + S;
    assign yt = {1'b0, bullet_y};
    assign yb = yt + S;

    always_comb begin
        x0     = xl;
        y0     = yt;
        x1     = xl;
        y1     = yt;
        dir_ok = 1'b1;
        case (bullet_dir)
            4'b0001: x1 = xr;
            4'b0010: begin y0 = yb; x1 = xr; y1 = yb; end
            4'b0100: y1 = yb;
            4'b1000: begin x0 = xr; x1 = xr; y1 = yb; end
            default: dir_ok = 1'b0;
        endcase
    end

    logic          v0, v1, h0, h1, same;
    logic [RW-1:0] r0, r1;
    logic [CW-1:0] b0, b1;
    logic [1:0]    n_clr;

    assign v0 = dir_ok && (x0 <= X_MAX) && (y0 <= Y_MAX);
    assign v1 = dir_ok && (x1 <= X_MAX) && (y1 <= Y_MAX);
    assign r0 = y0[4 +: RW];
    assign r1 = y1[4 +: RW];
    assign b0 = CW'(COLS - 1) - x0[4 +: CW];
    assign b1 = CW'(COLS - 1) - x1[4 +: CW];
    assign h0 = v0 && brick_map[r0][b0];
    assign h1 = v1 && brick_map[r1][b1];
    assign same  = (r0 == r1) && (b0 == b1);
    assign n_clr = 2'(h0) + 2'(h1 && !(h0 && same));

    assign all_clear = ready && (bricks_left == 11'd0);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            for (int i = 0; i < ROWS; i++) brick_map[i] <= '0;
            bricks_left <= '0;
            bullet_hit  <= 1'b0;
            ready       <= 1'b0;
            state       <= LOAD;
            rc          <= '0;
        end else begin
            bullet_hit <= 1'b0;
            case (state)
                LOAD: begin
                    brick_map[rc] <= load_row;
                    bricks_left   <= bricks_left + load_cnt;
                    rc            <= rc + 1'b1;
                    if (rc == RW'(ROWS - 1)) begin
                        ready <= 1'b1;
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (bullet_active && (h0 || h1)) begin
                        if (h0) brick_map[r0][b0] <= 1'b0;
                        if (h1) brick_map[r1][b1] <= 1'b0;
                        bricks_left <= bricks_left - 11'(n_clr);
                        bullet_hit  <= 1'b1;
                        state       <= SPENT;
                    end
                end
                SPENT: begin
                    if (!bullet_active) state <= ARMED;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
